canvas_writer: RTL

CANVAS_WRITER -- requirements
Module: canvas_writer

---
 rtl/canvas_writer.sv | 102 ++++++++++
 1 files changed

// File: rtl/canvas_writer.sv
// Frame-buffer writer: scales screen coordinates into a linear address, writes pixels
// with a fixed 2-cycle latency and can sweep the whole buffer to a clear colour.
module canvas_writer #(
    parameter int         FB_WIDTH    = 320,
    parameter int         FB_HEIGHT   = 180,
    parameter int         SCALE_SHIFT = 2,
    parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    input  logic [7:0]  color_in,
    input  logic        clear_in,
    output logic [15:0] addr_out,
    output logic [7:0]  data_out,
    output logic        we_out,
    output logic        busy_out,
    output logic [15:0] write_count_out,
    output logic [15:0] drop_count_out
);
    localparam int N = FB_WIDTH * FB_HEIGHT;

    typedef enum logic {IDLE, CLEARING} state_t;
    state_t state, state_next;

    logic [16:0] clr_cnt;
    logic [10:0] col;
    logic [9:0]  row;
    logic        in_bounds;
    logic [15:0] addr_calc;
    logic        accept, drop, clr_wr;

    // Stage 1 of the pixel pipeline; the output registers form stage 2.
    logic        s1_vld;
    logic [15:0] s1_addr;
    logic [7:0]  s1_color;

    assign col       = hcount_in >> SCALE_SHIFT;
    assign row       = vcount_in >> SCALE_SHIFT;
    assign in_bounds = (int'(col) < FB_WIDTH) && (int'(row) < FB_HEIGHT);
    assign addr_calc = 16'(int'(row) * FB_WIDTH + int'(col));
    assign busy_out  = (state == CLEARING);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        clr_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (clear_in) begin
                    state_next = CLEARING;
                    drop       = data_valid_in;
                end else if (data_valid_in) begin
                    accept = in_bounds;
                    drop   = !in_bounds;
                end
            end
            CLEARING: begin
                drop = data_valid_in;
                // One extra busy cycle after the last clear write before returning idle.
                if (int'(clr_cnt) == N) state_next = IDLE;
                else                    clr_wr     = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            clr_cnt         <= '0;
            s1_vld          <= 1'b0;
            s1_addr         <= '0;
            s1_color        <= '0;
            we_out          <= 1'b0;
            addr_out        <= '0;
            data_out        <= '0;
            write_count_out <= '0;
            drop_count_out  <= '0;
        end else begin
            state    <= state_next;
            clr_cnt  <= (state == IDLE) ? '0 : (clr_wr ? clr_cnt + 17'd1 : clr_cnt);
            s1_vld   <= accept;
            s1_addr  <= addr_calc;
            s1_color <= color_in;
            // Stage 1 is always empty while clear writes are issued, so no arbitration is needed.
            we_out   <= s1_vld | clr_wr;
            if (s1_vld) begin
                addr_out <= s1_addr;
                data_out <= s1_color;
            end else if (clr_wr) begin
                addr_out <= clr_cnt[15:0];
                data_out <= CLEAR_COLOR;
            end
            if (s1_vld && write_count_out != 16'hFFFF) write_count_out <= write_count_out + 16'd1;
            if (drop && drop_count_out != 16'hFFFF)    drop_count_out  <= drop_count_out + 16'd1;
        end
    end
endmodule
